// File: rtl/b16_debug_ctrl_if.sv
// Host link for the b16 debug controller: command byte stream in, response byte stream out.
interface b16_debug_ctrl_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;

    modport master (
        output cmd_data, cmd_valid, rsp_ready,
        input  cmd_ready, rsp_data, rsp_valid
    );

    modport slave (
        input  cmd_data, cmd_valid, rsp_ready,
        output cmd_ready, rsp_data, rsp_valid
    );
endinterface

// File: rtl/b16_debug_ctrl.sv
// Byte-serial debug controller for the b16 core: halt/go/step, register access, one fetch breakpoint.
//
// state  | meaning
// IDLE   | waiting for a command byte
// ARG_HI | waiting for high argument byte (WRREG data / SETBP address)
// ARG_LO | waiting for low argument byte
// EXEC   | one cycle: side effect applied, dr/dw pulse, response byte latched
// TX_HI  | presenting high byte of a register read
// TX_LO  | presenting the final (or only) response byte
module b16_debug_ctrl #(
    parameter logic        RUN_AT_RESET = 1'b1,
    parameter logic [15:0] BP_RESET     = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    nreset,
    b16_debug_ctrl_if.slave         link,
    input  logic [15:0]             cpu_addr,
    input  logic                    cpu_rd,
    output logic                    run,
    output logic                    dr,
    output logic                    dw,
    output logic [2:0]              daddr,
    output logic [15:0]             din,
    input  logic [15:0]             dout,
    output logic [15:0]             bp
);

    typedef enum logic [2:0] {IDLE, ARG_HI, ARG_LO, EXEC, TX_HI, TX_LO} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cmd_q, rsp_q, rsp_nxt;
    logic [15:0] sh;
    logic        bp_en, hit, mask, step_pend;
    logic        run_nxt, hit_nxt;
    logic        cmd_rdy, rsp_vld;
    logic        ex, is_rd, is_wr, do_rd, do_wr, do_halt, do_go, do_step, do_setbp, do_clrbp;
    logic        hit_now, new_has_args;

    assign ex       = (state == EXEC);
    assign is_rd    = (cmd_q[7:3] == 5'b00000);
    assign is_wr    = (cmd_q[7:3] == 5'b01000);
    assign do_rd    = ex && is_rd && !run;
    assign do_wr    = ex && is_wr && !run;
    assign do_halt  = ex && (cmd_q == 8'h80);
    assign do_go    = ex && (cmd_q == 8'h81);
    assign do_step  = ex && (cmd_q == 8'h82) && !run;
    assign do_setbp = ex && (cmd_q == 8'h83);
    assign do_clrbp = ex && (cmd_q == 8'h84);

    // mask lets the core refetch the breakpoint address right after resuming
    assign hit_now  = run && bp_en && cpu_rd && (cpu_addr == bp) && !mask;

    assign new_has_args = (link.cmd_data[7:3] == 5'b01000) || (link.cmd_data == 8'h83);

    assign link.cmd_ready = cmd_rdy;
    assign link.rsp_valid = rsp_vld;
    assign link.rsp_data  = rsp_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_rdy   = 1'b0;
        rsp_vld   = 1'b0;
        dr        = 1'b0;
        dw        = 1'b0;
        case (state)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (link.cmd_valid) state_nxt = new_has_args ? ARG_HI : EXEC;
            end
            ARG_HI: begin
                cmd_rdy = 1'b1;
                if (link.cmd_valid) state_nxt = ARG_LO;
            end
            ARG_LO: begin
                cmd_rdy = 1'b1;
                if (link.cmd_valid) state_nxt = EXEC;
            end
            EXEC: begin
                dr        = do_rd;
                dw        = do_wr;
                state_nxt = do_rd ? TX_HI : TX_LO;
            end
            TX_HI: begin
                rsp_vld = 1'b1;
                if (link.rsp_ready) state_nxt = TX_LO;
            end
            TX_LO: begin
                rsp_vld = 1'b1;
                if (link.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rsp_nxt = 8'hFF;
        if (is_rd && !run)      rsp_nxt = dout[15:8];
        else if (is_wr && !run) rsp_nxt = cmd_q;
        else begin
            case (cmd_q)
                8'h80, 8'h81, 8'h83, 8'h84: rsp_nxt = cmd_q;
                8'h82:                      rsp_nxt = run ? 8'hFF : cmd_q;
                8'h85:                      rsp_nxt = {run, bp_en, hit, 5'b0};
                default:                    rsp_nxt = 8'hFF;
            endcase
        end
    end

    // later assignments win: a GO overrides a coincident breakpoint hit
    always_comb begin
        run_nxt = run;
        hit_nxt = hit;
        if (step_pend) run_nxt = 1'b0;
        if (hit_now) begin
            run_nxt = 1'b0;
            hit_nxt = 1'b1;
        end
        if (do_halt) run_nxt = 1'b0;
        if (do_go || do_step) begin
            run_nxt = 1'b1;
            hit_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            run       <= RUN_AT_RESET;
            hit       <= 1'b0;
            mask      <= 1'b0;
            step_pend <= 1'b0;
            bp        <= BP_RESET;
            bp_en     <= 1'b0;
            cmd_q     <= 8'h00;
            rsp_q     <= 8'h00;
            sh        <= 16'h0000;
            daddr     <= 3'd0;
            din       <= 16'h0000;
        end else begin
            run       <= run_nxt;
            hit       <= hit_nxt;
            mask      <= do_go || do_step;
            step_pend <= do_step;
            case (state)
                IDLE: if (link.cmd_valid) begin
                    cmd_q <= link.cmd_data;
                    if (link.cmd_data[7:3] == 5'b00000 || link.cmd_data[7:3] == 5'b01000)
                        daddr <= link.cmd_data[2:0];
                end
                ARG_HI: if (link.cmd_valid) begin
                    sh[15:8] <= link.cmd_data;
                    if (is_wr) din[15:8] <= link.cmd_data;
                end
                ARG_LO: if (link.cmd_valid) begin
                    sh[7:0] <= link.cmd_data;
                    if (is_wr) din[7:0] <= link.cmd_data;
                end
                EXEC: begin
                    rsp_q <= rsp_nxt;
                    if (do_rd)    sh    <= dout;
                    if (do_setbp) begin
                        bp    <= sh;
                        bp_en <= 1'b1;
                    end
                    if (do_clrbp) bp_en <= 1'b0;
                end
                TX_HI: if (link.rsp_ready) rsp_q <= sh[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_b16_debug_ctrl.sv
// Self-checking bench for b16_debug_ctrl: directed scenarios plus randomized commands against a command-level model.
module tb_b16_debug_ctrl;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    b16_debug_ctrl_if link();

    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rd = 1'b0;
    logic        run, dr, dw;
    logic [2:0]  daddr;
    logic [15:0] din, dout, bp;
    logic [15:0] rd_val = 16'h0000;

    // core register file model: value depends on the selected register
    assign dout = rd_val ^ {13'b0, daddr};

    b16_debug_ctrl #(.RUN_AT_RESET(1'b1), .BP_RESET(16'hFFFF)) dut (
        .clk(clk), .nreset(nreset), .link(link.slave),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .run(run), .dr(dr), .dw(dw),
        .daddr(daddr), .din(din), .dout(dout), .bp(bp)
    );

    int checks = 0;
    int failures = 0;

    int dr_cnt = 0, dw_cnt = 0, run_hi = 0, viol = 0;
    logic [2:0]  dw_addr = 3'd0;
    logic [15:0] dw_din = 16'h0;
    always @(negedge clk) begin
        if (dr) dr_cnt++;
        if (dw) begin
            dw_cnt++;
            dw_addr = daddr;
            dw_din  = din;
        end
        if (run) run_hi++;
        if ((run && (dr || dw)) || (dr && dw)) viol++;
    end

    // command-level model of the controller's architectural state
    logic        m_run = 1'b1, m_bp_en = 1'b0, m_hit = 1'b0;
    logic [15:0] m_bp = 16'hFFFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        link.cmd_data  = b;
        link.cmd_valid = 1'b1;
        while (!link.cmd_ready && n < 40) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", link.cmd_ready, 1);
        tick();
        link.cmd_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input int stall);
        int n = 0;
        link.rsp_ready = 1'b0;
        while (!link.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("rsp_valid_wait", link.rsp_valid, 1);
        repeat (stall) tick();
        b = link.rsp_data;
        link.rsp_ready = 1'b1;
        tick();
        link.rsp_ready = 1'b0;
    endtask

    task automatic model_reset();
        m_run = 1'b1; m_bp_en = 1'b0; m_hit = 1'b0; m_bp = 16'hFFFF;
    endtask

    task automatic run_cmd(input logic [7:0] c, input logic [15:0] arg, input string tag);
        logic [7:0]  r0, r1, got;
        logic [15:0] v;
        bit          two, edr, edw, estep, has_args;
        int dr0 = dr_cnt, dw0 = dw_cnt, rh0 = run_hi;
        has_args = (c inside {[8'h40:8'h47]}) || (c == 8'h83);
        two = 0; edr = 0; edw = 0; estep = 0; r0 = 8'hFF; r1 = 8'h00;
        if (c inside {[8'h00:8'h07]}) begin
            if (!m_run) begin
                v = rd_val ^ {13'b0, c[2:0]};
                r0 = v[15:8]; r1 = v[7:0]; two = 1; edr = 1;
            end
        end else if (c inside {[8'h40:8'h47]}) begin
            if (!m_run) begin r0 = c; edw = 1; end
        end else begin
            case (c)
                8'h80: begin r0 = c; m_run = 1'b0; end
                8'h81: begin r0 = c; m_run = 1'b1; m_hit = 1'b0; end
                8'h82: if (!m_run) begin r0 = c; m_hit = 1'b0; estep = 1; end
                8'h83: begin r0 = c; m_bp = arg; m_bp_en = 1'b1; end
                8'h84: begin r0 = c; m_bp_en = 1'b0; end
                8'h85: r0 = {m_run, m_bp_en, m_hit, 5'b0};
                default: ;
            endcase
        end
        send_byte(c);
        if (has_args) begin
            send_byte(arg[15:8]);
            send_byte(arg[7:0]);
        end
        recv_byte(got, $urandom_range(0, 3));
        chk({tag, "_rsp"}, got, r0);
        if (two) begin
            recv_byte(got, $urandom_range(0, 3));
            chk({tag, "_rsp_lo"}, got, r1);
        end
        chk({tag, "_dr_pulses"}, dr_cnt - dr0, edr);
        chk({tag, "_dw_pulses"}, dw_cnt - dw0, edw);
        if (edw) begin
            chk({tag, "_dw_din"}, dw_din, arg);
            chk({tag, "_dw_addr"}, dw_addr, c[2:0]);
        end
        if (estep) chk({tag, "_step_run_cycles"}, run_hi - rh0, 1);
        chk({tag, "_run"}, run, m_run);
        chk({tag, "_bp"}, bp, m_bp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  got;
        logic [15:0] v;
        link.cmd_data = 8'h00; link.cmd_valid = 1'b0; link.rsp_ready = 1'b0;
        nreset = 1'b0;
        repeat (3) tick();
        chk("reset_run", run, 1);
        chk("reset_bp", bp, 16'hFFFF);
        chk("reset_rsp_valid", link.rsp_valid, 0);
        chk("reset_dr_dw", {dr, dw}, 0);
        nreset = 1'b1;
        tick();

        // status, halt, status
        run_cmd(8'h85, 16'h0, "status_run");
        run_cmd(8'h80, 16'h0, "halt");
        run_cmd(8'h85, 16'h0, "status_halted");

        // register write and read while halted
        run_cmd(8'h41, 16'h1234, "wrreg1");
        rd_val = 16'hBEEF ^ 16'h0004;
        run_cmd(8'h04, 16'h0, "rdreg4");

        // breakpoint hit
        run_cmd(8'h83, 16'h2000, "setbp");
        run_cmd(8'h81, 16'h0, "go");
        cpu_addr = 16'h1FFE; cpu_rd = 1'b1;
        tick();
        chk("bp_nonmatch_run", run, 1);
        cpu_addr = 16'h2000;
        tick();
        cpu_rd = 1'b0;
        m_run = 1'b0; m_hit = 1'b1;
        chk("bp_hit_run", run, 0);
        run_cmd(8'h85, 16'h0, "status_hit");

        // resume from breakpoint: fetch at bp in the mask cycle must not re-hit
        send_byte(8'h81);
        m_run = 1'b1; m_hit = 1'b0;
        tick();
        cpu_rd = 1'b1; cpu_addr = 16'h2000;
        tick();
        cpu_rd = 1'b0;
        chk("resume_no_rehit", run, 1);
        recv_byte(got, 0);
        chk("resume_rsp", got, 8'h81);

        // single step, then step/read refused while running
        run_cmd(8'h80, 16'h0, "halt2");
        run_cmd(8'h82, 16'h0, "step");
        run_cmd(8'h81, 16'h0, "go2");
        run_cmd(8'h82, 16'h0, "step_running");
        run_cmd(8'h04, 16'h0, "rdreg_running");
        run_cmd(8'h80, 16'h0, "halt3");

        // response back-pressure, then reset while a response is pending
        rd_val = 16'($urandom);
        v = rd_val ^ 16'h0003;
        send_byte(8'h03);
        for (int i = 0; i < 40 && !link.rsp_valid; i++) tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_rsp_valid", link.rsp_valid, 1);
            chk("stall_rsp_data", link.rsp_data, v[15:8]);
            chk("stall_cmd_ready", link.cmd_ready, 0);
            tick();
        end
        link.rsp_ready = 1'b1;
        tick();
        link.rsp_ready = 1'b0;
        chk("stall_lo_byte", link.rsp_data, v[7:0]);
        nreset = 1'b0;
        #1;
        model_reset();
        chk("rst_run", run, 1);
        chk("rst_bp", bp, 16'hFFFF);
        chk("rst_rsp_valid", link.rsp_valid, 0);
        chk("rst_rsp_data", link.rsp_data, 0);
        chk("rst_daddr_din", {daddr, din}, 0);
        chk("rst_dr_dw", {dr, dw}, 0);
        tick();
        tick();
        nreset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_rsp", link.rsp_valid, 0);
        end

        // undefined byte has no side effects
        run_cmd(8'h9C, 16'h0, "undef");
        run_cmd(8'h85, 16'h0, "status_after_undef");

        // randomized command mix
        for (int it = 0; it < 40; it++) begin
            logic [7:0] c;
            int kind;
            kind   = $urandom_range(0, 9);
            rd_val = 16'($urandom);
            case (kind)
                0, 9: c = {5'b00000, 3'($urandom_range(0, 7))};
                1:    c = {5'b01000, 3'($urandom_range(0, 7))};
                8:    c = 8'($urandom);
                default: c = 8'h80 + 8'(kind - 2);
            endcase
            run_cmd(c, 16'($urandom), "rand");
        end

        chk("dr_dw_rules", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
